psram_port_mux: RTL and testbench

//  Multi-channel byte-access controller for one async 16-bit PSRAM chip. Arbitrates NCH byte

---
 rtl/psram_pkg.sv | 29 ++
 rtl/psram_port_mux_if.sv | 15 +
 rtl/psram_rr_arb.sv | 45 ++++
 rtl/psram_port_mux.sv | 157 +++++++++++++++
 tb/tb_psram_port_mux.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/psram_pkg.sv
// Shared types for the PSRAM port mux: FSM states, strobe bundle and byte-lane helpers.
package psram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StRecover
  } state_e;

  // Chip strobes, all active-low.
  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
  } strobe_t;

  // Returns {ub_n, lb_n}: even byte address selects the upper byte.
  function automatic logic [1:0] lane_n(input logic a0);
    return a0 ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [7:0] rd_byte(input logic [15:0] din, input logic a0);
    return a0 ? din[7:0] : din[15:8];
  endfunction

endpackage

// File: rtl/psram_port_mux_if.sv
// Requester-side byte bus of the PSRAM port mux: NCH request channels plus shared read data.
interface psram_port_mux_if #(
  parameter int unsigned NCH = 2,
  parameter int unsigned AW  = 23
) ();
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    we;
  logic [NCH*AW-1:0] addr;
  logic [NCH*8-1:0]  wdat;
  logic [NCH-1:0]    ack;
  logic [7:0]        rdat;

  modport master (output req, we, addr, wdat, input ack, rdat);
  modport slave  (input req, we, addr, wdat, output ack, rdat);
endinterface

// File: rtl/psram_rr_arb.sv
// Round-robin request arbiter; PSRAM_CH0_PRIO_EN gives channel 0 absolute priority.
module psram_rr_arb #(
  parameter int unsigned NCH = 2,
  parameter int unsigned PW  = 1
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  rr_ptr,
  output logic [NCH-1:0] gnt,
  output logic [PW-1:0]  idx
);

  logic           prio;
  logic [NCH-1:0] req_rr;

`ifdef PSRAM_CH0_PRIO_EN
  assign prio   = req[0];
  assign req_rr = req & ~NCH'(1);
`else
  assign prio   = 1'b0;
  assign req_rr = req;
`endif

  always_comb begin
    int unsigned c;
    logic        found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    if (prio) begin
      gnt[0] = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        c = 32'(rr_ptr) + k;
        if (c >= NCH) c = c - NCH;
        if (!found && req_rr[c]) begin
          found  = 1'b1;
          gnt[c] = 1'b1;
          idx    = PW'(c);
        end
      end
    end
  end

endmodule

// File: rtl/psram_port_mux.sv
// Multi-channel byte-access controller for one async 16-bit PSRAM.
// Optional PSRAM_CH0_PRIO_EN (in psram_rr_arb) makes channel 0 the priority requester.
module psram_port_mux
  import psram_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned AW    = 23,
  parameter int unsigned T_RD  = 4,
  parameter int unsigned T_WR  = 4,
  parameter int unsigned T_REC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  psram_port_mux_if.slave   bus,
  output logic [AW-2:0]     ram_addr,
  output logic [15:0]       ram_dout,
  output logic              ram_drv,
  input  logic [15:0]       ram_din,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              ram_ub_n,
  output logic              ram_lb_n
);

  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   gnt_idx_q, gnt_idx_d;
  logic            we_q, we_d;
  logic            a0_q, a0_d;
  logic [AW-2:0]   ram_addr_q, ram_addr_d;
  logic [15:0]     ram_dout_q, ram_dout_d;
  logic            drv_q, drv_d;
  strobe_t         strb_q, strb_d;
  logic [7:0]      rdat_q, rdat_d;
  logic [NCH-1:0]  ack_q, ack_d;

  logic [NCH-1:0]  arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic [AW-1:0]   win_addr;
  logic [7:0]      win_wdat;

  psram_rr_arb #(
    .NCH (NCH),
    .PW  (PW)
  ) u_arb (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .gnt    (arb_gnt),
    .idx    (arb_idx)
  );

  assign win_addr = bus.addr[arb_idx*AW +: AW];
  assign win_wdat = bus.wdat[arb_idx*8 +: 8];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_idx_d  = gnt_idx_q;
    we_d       = we_q;
    a0_d       = a0_q;
    ram_addr_d = ram_addr_q;
    ram_dout_d = ram_dout_q;
    drv_d      = drv_q;
    strb_d     = strb_q;
    rdat_d     = rdat_q;
    ack_d      = '0;
    case (state_q)
      StIdle: begin
        // Winner's fields load straight into the pin registers so SETUP already shows them.
        if (|arb_gnt) begin
          state_d    = StSetup;
          gnt_idx_d  = arb_idx;
          rr_ptr_d   = (32'(arb_idx) == NCH - 1) ? '0 : arb_idx + 1'b1;
          we_d       = bus.we[arb_idx];
          a0_d       = win_addr[0];
          ram_addr_d = win_addr[AW-1:1];
          ram_dout_d = {win_wdat, win_wdat};
          drv_d      = bus.we[arb_idx];
          strb_d.ce_n = 1'b0;
          strb_d.oe_n = 1'b1;
          strb_d.we_n = 1'b1;
          {strb_d.ub_n, strb_d.lb_n} = lane_n(win_addr[0]);
        end
      end
      StSetup: begin
        state_d     = StAccess;
        cnt_d       = we_q ? 8'(T_WR - 1) : 8'(T_RD - 1);
        strb_d.oe_n = we_q;
        strb_d.we_n = ~we_q;
      end
      StAccess: begin
        if (cnt_q == '0) begin
          state_d          = StRecover;
          cnt_d            = 8'(T_REC - 1);
          strb_d           = '1;
          drv_d            = 1'b0;
          ack_d[gnt_idx_q] = 1'b1;
          if (!we_q) rdat_d = rd_byte(ram_din, a0_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRecover: begin
        if (cnt_q == '0) state_d = StIdle;
        else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      gnt_idx_q  <= '0;
      we_q       <= 1'b0;
      a0_q       <= 1'b0;
      ram_addr_q <= '0;
      ram_dout_q <= '0;
      drv_q      <= 1'b0;
      strb_q     <= '1;
      rdat_q     <= '0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      we_q       <= we_d;
      a0_q       <= a0_d;
      ram_addr_q <= ram_addr_d;
      ram_dout_q <= ram_dout_d;
      drv_q      <= drv_d;
      strb_q     <= strb_d;
      rdat_q     <= rdat_d;
      ack_q      <= ack_d;
    end
  end

  assign bus.ack  = ack_q;
  assign bus.rdat = rdat_q;
  assign ram_addr = ram_addr_q;
  assign ram_dout = ram_dout_q;
  assign ram_drv  = drv_q;
  assign ram_ce_n = strb_q.ce_n;
  assign ram_oe_n = strb_q.oe_n;
  assign ram_we_n = strb_q.we_n;
  assign ram_ub_n = strb_q.ub_n;
  assign ram_lb_n = strb_q.lb_n;

endmodule

// File: tb/tb_psram_port_mux.sv
// Scoreboard bench for psram_port_mux (NCH=4) with a behavioural 16-bit PSRAM model.
module tb_psram_port_mux;
  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 23;
  localparam int unsigned TRD = 4;
  localparam int unsigned TWR = 4;

  typedef struct {
    int          ch;
    bit          wr;
    logic [22:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [21:0] ram_addr;
  logic [15:0] ram_dout;
  logic        ram_drv;
  logic [15:0] ram_din;
  logic        ram_ce_n, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n;

  logic [15:0] mem [0:255];
  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          ack_total = 0;

  psram_port_mux_if #(.NCH(NCH), .AW(AW)) bus ();

  psram_port_mux #(
    .NCH   (NCH),
    .AW    (AW),
    .T_RD  (TRD),
    .T_WR  (TWR),
    .T_REC (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .ram_drv  (ram_drv),
    .ram_din  (ram_din),
    .ram_ce_n (ram_ce_n),
    .ram_oe_n (ram_oe_n),
    .ram_we_n (ram_we_n),
    .ram_ub_n (ram_ub_n),
    .ram_lb_n (ram_lb_n)
  );

  always #10 clk = ~clk;

  assign ram_din = mem[ram_addr[7:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // PSRAM model: byte writes on each clock edge with we_n low.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[1]    = 16'hA55A;
    mem[8'h10] = 16'hBEEF;
    forever begin
      @(posedge clk);
      if (!ram_ce_n && !ram_we_n && ram_drv) begin
        if (!ram_ub_n) mem[ram_addr[7:0]][15:8] = ram_dout[15:8];
        if (!ram_lb_n) mem[ram_addr[7:0]][7:0]  = ram_dout[7:0];
      end
    end
  end

  // Monitor: captures access-phase pin state, checks each ack against the scoreboard.
  initial begin
    int          wlow, olow;
    logic [21:0] cap_addr;
    logic [15:0] cap_dout;
    logic        cap_ub, cap_lb, cap_drv;
    exp_t        e;
    wlow = 0; olow = 0;
    cap_addr = '0; cap_dout = '0; cap_ub = 1'b1; cap_lb = 1'b1; cap_drv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wlow = 0;
        olow = 0;
      end else begin
        if (!ram_ce_n) begin
          cap_addr = ram_addr; cap_dout = ram_dout;
          cap_ub = ram_ub_n; cap_lb = ram_lb_n; cap_drv = ram_drv;
        end else begin
          chk("drv_idle", {31'd0, ram_drv}, 32'd0);
        end
        if (!ram_we_n) wlow++;
        if (!ram_oe_n) olow++;
        if (!ram_ub_n && !ram_lb_n) chk("lanes_both_low", 32'd1, 32'd0);
        if (bus.ack != '0) begin
          ack_total++;
          chk("ack_onehot", {31'd0, $onehot(bus.ack)}, 32'd1);
          if (q.size() == 0) begin
            chk("unexpected_ack", {28'd0, bus.ack}, 32'd0);
          end else begin
            e = q.pop_front();
            chk("ack_ch", {28'd0, bus.ack}, 32'd1 << e.ch);
            chk("ram_addr", {10'd0, cap_addr}, {10'd0, e.addr[22:1]});
            chk("ub_n", {31'd0, cap_ub}, {31'd0, e.addr[0]});
            chk("lb_n", {31'd0, cap_lb}, {31'd0, ~e.addr[0]});
            if (e.wr) begin
              chk("we_low_cycles", wlow, TWR);
              chk("oe_low_wr", olow, 0);
              chk("ram_dout", {16'd0, cap_dout}, {16'd0, e.data, e.data});
              chk("drv_wr", {31'd0, cap_drv}, 32'd1);
            end else begin
              chk("oe_low_cycles", olow, TRD);
              chk("we_low_rd", wlow, 0);
              chk("rdat", {24'd0, bus.rdat}, {24'd0, e.data});
              chk("drv_rd", {31'd0, cap_drv}, 32'd0);
            end
          end
          wlow = 0;
          olow = 0;
        end
      end
    end
  end

  task automatic set_ch(input int ch, input bit wr, input logic [22:0] a, input logic [7:0] d);
    bus.we[ch] = wr;
    bus.addr[ch*AW +: AW] = a;
    bus.wdat[ch*8 +: 8] = d;
  endtask

  task automatic push(input int ch, input bit wr, input logic [22:0] a, input logic [7:0] d);
    exp_t e;
    e.ch = ch; e.wr = wr; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  // One isolated transaction, raised mid-IDLE; checks req-to-ack latency.
  task automatic do_req(input int ch, input bit wr, input logic [22:0] a, input logic [7:0] d,
                        input bit early_drop);
    int n;
    bit got;
    push(ch, wr, a, d);
    set_ch(ch, wr, a, wr ? d : 8'hC3);
    bus.req[ch] = 1'b1;
    n = 0;
    got = 0;
    while (!got && n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (early_drop && n == 2) bus.req[ch] = 1'b0;
      if (bus.ack[ch]) got = 1;
    end
    chk("latency", n, wr ? 2 + TWR : 2 + TRD);
    bus.req[ch] = 1'b0;
    @(negedge clk);
  endtask

  // Several channels requesting at once; optionally re-raise after each ack.
  task automatic multi_req(input logic [NCH-1:0] mask, input int nacks, input bit reraise);
    int acks, n;
    acks = 0;
    n = 0;
    bus.req = mask;
    while (acks < nacks && n < 300) begin
      @(negedge clk);
      n++;
      if (reraise) bus.req = mask;
      for (int k = 0; k < NCH; k++) begin
        if (bus.ack[k]) begin
          bus.req[k] = 1'b0;
          acks++;
        end
      end
    end
    bus.req = '0;
    chk("multi_acks", acks, nacks);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int wr_ch [7]   = '{2, 3, 0, 1, 0, 3, 2};
    bit wr_wr [7]   = '{1, 1, 1, 0, 0, 0, 0};
    logic [22:0] wr_a [7] = '{23'h40, 23'h41, 23'h41, 23'h40, 23'h41, 23'h40, 23'h41};
    logic [7:0]  wr_d [7] = '{8'h11, 8'h22, 8'h99, 8'h11, 8'h99, 8'h11, 8'h99};
    bus.req = '0;
    bus.we = '0;
    bus.addr = '0;
    bus.wdat = '0;
    repeat (3) @(negedge clk);
    chk("rst_ce_n", {31'd0, ram_ce_n}, 32'd1);
    chk("rst_strobes", {27'd0, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n, ram_drv}, 32'h1E);
    chk("rst_ack", {28'd0, bus.ack}, 32'd0);
    chk("rst_rdat", {24'd0, bus.rdat}, 32'd0);
    chk("rst_ram_addr", {10'd0, ram_addr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read of the upper byte, then a lower-byte write.
    do_req(0, 1'b0, 23'h000002, 8'hA5, 1'b0);
    do_req(1, 1'b1, 23'h000007, 8'h3C, 1'b0);
    chk("mem_write", {16'd0, mem[3]}, 32'h003C);

    // Two channels held: round-robin alternates unless channel 0 has priority.
    set_ch(0, 1'b0, 23'h20, 8'h00);
    set_ch(1, 1'b0, 23'h21, 8'h00);
`ifdef PSRAM_CH0_PRIO_EN
    for (int i = 0; i < 4; i++) push(0, 1'b0, 23'h20, 8'hBE);
`else
    push(0, 1'b0, 23'h20, 8'hBE);
    push(1, 1'b0, 23'h21, 8'hEF);
    push(0, 1'b0, 23'h20, 8'hBE);
    push(1, 1'b0, 23'h21, 8'hEF);
`endif
    multi_req(4'b0011, 4, 1'b1);

    // Reset in the middle of a write.
    set_ch(1, 1'b1, 23'h80, 8'h55);
    bus.req[1] = 1'b1;
    n = 0;
    while (ram_we_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("we_low_seen", {31'd0, ram_we_n}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_we_ce", {30'd0, ram_we_n, ram_ce_n}, 32'd3);
    chk("arst_drv", {31'd0, ram_drv}, 32'd0);
    chk("arst_ack", {28'd0, bus.ack}, 32'd0);
    chk("arst_rdat", {24'd0, bus.rdat}, 32'd0);
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // rr_ptr back at 0: channel 1 must beat channel 2.
    set_ch(1, 1'b0, 23'h20, 8'h00);
    set_ch(2, 1'b0, 23'h21, 8'h00);
    push(1, 1'b0, 23'h20, 8'hBE);
    push(2, 1'b0, 23'h21, 8'hEF);
    multi_req(4'b0110, 2, 1'b0);

    // Request dropped right after grant still completes exactly once.
    n = ack_total;
    do_req(3, 1'b0, 23'h000003, 8'h5A, 1'b1);
    repeat (12) @(negedge clk);
    chk("early_drop_acks", ack_total - n, 1);

    // Write/read table across all four channels.
    for (int i = 0; i < 7; i++) do_req(wr_ch[i], wr_wr[i], wr_a[i], wr_d[i], 1'b0);

    repeat (10) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
